// File: rtl/ifu_pkg.sv
// Shared IFU definitions: fetch-responder FSM encoding, fault filler and reset PC.
package ifu_pkg;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;

  // Picks the 32-bit instruction out of an aligned 64-bit word.
  function automatic logic [31:0] word_sel(input logic hi, input logic [63:0] word);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// One-entry line buffer holding the last good 64-bit instruction word and its tag.
module fetch_line_buf (
  input  logic        clk,
  input  logic        rstn,
  input  logic [60:0] lookup_tag,
  input  logic        fill,
  input  logic        invalidate,
  input  logic [60:0] fill_tag,
  input  logic [63:0] fill_data,
  output logic        hit,
  output logic [63:0] data
);

  logic        valid;
  logic [60:0] tag;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= 1'b0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
    end
  end

  // NOTE: tag/data need no reset; they are never observed while valid is low.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag  <= fill_tag;
      data <= fill_data;
    end
  end

  assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/ifu_fetch_resp.sv
// IFU fetch responder: answers pc with an instruction, from the line buffer or one memory read.
module ifu_fetch_resp
  import ifu_pkg::*;
#(
  parameter bit NOP_ON_FAULT = 1'b1,
  parameter bit BUF_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] pc,
  input  logic        fence_i,
  output logic [31:0] instr,
  output logic        ifu_update,
  output logic        fetch_fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  input  logic        mem_rsp_err
);

  localparam logic [31:0] FAULT_INSTR = NOP_ON_FAULT ? NOP_INSTR : 32'h0;

  fetch_state_t state_q, state_d;
  logic [63:2]  req_pc_q, req_pc_d;
  logic [31:0]  instr_d;
  logic         update_d, fault_d, req_valid_d;
  logic [63:0]  req_addr_d;
  logic         fill;
  logic         raw_hit, buf_hit;
  logic [63:0]  buf_data;

  fetch_line_buf u_line_buf (
    .clk        (clk),
    .rstn       (rstn),
    .lookup_tag (pc[63:3]),
    .fill       (fill),
    .invalidate (fence_i),
    .fill_tag   (req_pc_q[63:3]),
    .fill_data  (mem_rsp_data),
    .hit        (raw_hit),
    .data       (buf_data)
  );

  assign buf_hit = BUF_EN && raw_hit;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    instr_d     = instr;
    update_d    = 1'b0;
    fault_d     = fetch_fault;
    req_valid_d = mem_req_valid;
    req_addr_d  = mem_req_addr;
    fill        = 1'b0;

    unique case (state_q)
      LOOKUP: begin
        req_pc_d = pc[63:2];
        if (pc[1:0] != 2'b00) begin
          state_d  = RESP;
          update_d = 1'b1;
          fault_d  = 1'b1;
          instr_d  = FAULT_INSTR;
        end else if (buf_hit) begin
          state_d  = RESP;
          update_d = 1'b1;
          fault_d  = 1'b0;
          instr_d  = word_sel(pc[2], buf_data);
        end else begin
          state_d     = REQ;
          req_valid_d = 1'b1;
          req_addr_d  = {pc[63:3], 3'b000};
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d  = RESP;
          update_d = 1'b1;
          if (mem_rsp_err) begin
            fault_d = 1'b1;
            instr_d = FAULT_INSTR;
          end else begin
            fill    = 1'b1;
            fault_d = 1'b0;
            instr_d = word_sel(req_pc_q[2], mem_rsp_data);
          end
        end
      end
      RESP:    state_d = LOOKUP;
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= LOOKUP;
      req_pc_q      <= '0;
      instr         <= '0;
      ifu_update    <= 1'b0;
      fetch_fault   <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      instr         <= instr_d;
      ifu_update    <= update_d;
      fetch_fault   <= fault_d;
      mem_req_valid <= req_valid_d;
      mem_req_addr  <= req_addr_d;
    end
  end

endmodule

// File: doc/ifu_fetch_resp.md
# ifu_fetch_resp

Instruction-fetch responder at the memory-side end of the IFU fetch interface. It watches the IFU's `pc`, returns the matching 32-bit `instr`, and pulses `ifu_update` for one cycle when the `pc`/`instr` pair is valid. It fetches aligned 64-bit words from instruction memory through a one-outstanding valid/ready port and keeps a one-word line buffer so sequential fetches from the same word skip memory. It sits between `ifu` and the instruction SRAM/bus bridge.

## Interface
- `NOP_ON_FAULT`, 1: drive `instr`=32'h13 on any fault; 0 drives 32'h0.
- `BUF_EN`, 1: enable the line buffer; 0 makes every lookup a miss.
- `clk` in 1: single clock.
- `rstn` in 1: reset, synchronous, active-low.
- `pc` in 64: fetch address from IFU; stable from lookup until `ifu_update`.
- `fence_i` in 1: invalidate the line buffer.
- `instr` out 32: instruction for `pc`; valid only while `ifu_update`=1.
- `ifu_update` out 1: one-cycle pulse; the IFU advances `pc` at this edge.
- `fetch_fault` out 1: qualifies `ifu_update`; misaligned `pc` or memory error.
- `mem_req_valid` out 1: read request.
- `mem_req_ready` in 1: request accepted when valid & ready.
- `mem_req_addr` out 64: request address, `{pc[63:3],3'b0}`.
- `mem_rsp_valid` in 1: response beat.
- `mem_rsp_data` in 64: response word.
- `mem_rsp_err` in 1: response error, qualifies `mem_rsp_valid`.

## Operation
- FSM states:
  - **LOOKUP**: samples `pc` into `req_pc`.
    - `pc[1:0]`≠0 → RESP with fault.
    - Buffer hit (`buf_valid` & `buf_tag`==`pc[63:3]` & `BUF_EN`) → RESP with data from the buffer.
    - Otherwise → REQ.
  - **REQ**: `mem_req_valid`=1 and `mem_req_addr` held from `req_pc`. Valid & ready → WAIT. Valid never drops before ready.
  - **WAIT**: waits for `mem_rsp_valid`.
    - `err`=0: fill the buffer (tag = `req_pc[63:3]`, data, valid=1), then → RESP.
    - `err`=1: leave the buffer untouched, then → RESP with fault.
  - **RESP**: `ifu_update`=1 for exactly one cycle, then → LOOKUP.
- Word select: `instr` = `req_pc[2]` ? `data[63:32]` : `data[31:0]`.
- Fault: `instr` = `NOP_ON_FAULT` ? 32'h13 : 32'h0, and `fetch_fault`=1.
- `fence_i`:
  - Clears `buf_valid` at the next edge in any state.
  - If it coincides with a WAIT fill, the fill's data is still returned but `buf_valid` ends at 0 (invalidate wins).
- `mem_rsp_valid` outside WAIT is ignored and dropped. This covers stale responses after a mid-fetch reset.
- Only one request is outstanding at a time. Responses arrive in order.

## Timing
- All outputs are registered. Reset values:
  - state = LOOKUP
  - `instr` = 0
  - `ifu_update` = 0
  - `fetch_fault` = 0
  - `mem_req_valid` = 0
  - `mem_req_addr` = 0
  - `buf_valid` = 0
- Hit: LOOKUP at cycle t, `ifu_update` at t+1. Sustained hit throughput is one instruction per 2 cycles.
- Miss:
  - LOOKUP at t.
  - `mem_req_valid` from t+1 until the handshake cycle h.
  - Response at cycle r ≥ h+1.
  - `ifu_update` at r+1.
  - Zero-wait memory gives 4 cycles per instruction.
- `ifu_update` is never high in two consecutive cycles. A new LOOKUP always uses the `pc` updated by the IFU at the previous edge.
- A refetch of the same `pc` (IFU hazard hold) hits the buffer.
- Reset asserted in any state returns the FSM to LOOKUP at the next edge, including during REQ with ready low.

## Structure
- Package `ifu_pkg` holds:
  - the FSM state encoding (LOOKUP/REQ/WAIT/RESP)
  - `NOP_INSTR`=32'h13
  - `RESET_PC`=64'h80000000, shared with `ifu`
- Sub-module `fetch_line_buf`:
  - registers: tag[60:0], data[63:0], valid
  - inputs: fill, invalidate (invalidate has priority)
  - combinational hit output
- Estimated size: ~200 lines total.

## Test plan
- **Reset then miss:** `pc`=0x8000_0000, ready=1, rsp data=0x0000_0013_0010_0093 two cycles after request → `mem_req_addr`=0x8000_0000, `ifu_update` with `instr`=0x0010_0093, fault=0.
- **Sequential hit:** after the fill above, `pc`=0x8000_0004 → no `mem_req_valid`; `ifu_update` one cycle after LOOKUP with `instr`=0x0000_0013.
- **Backpressure:** ready held low 5 cycles on a miss → `mem_req_valid` and `addr` stable for all 5 cycles; exactly one handshake; one `ifu_update`.
- **Faults:**
  - `pc`=0x8000_0002 → no memory request; `ifu_update` with `fetch_fault`=1 and `instr`=0x13.
  - Miss with `mem_rsp_err`=1 → fault, and the next same-word `pc` misses again.
- **fence_i:** `fence_i` pulsed in the same cycle as a WAIT fill → that fetch returns the fill's data; the next same-word lookup issues a memory request.
- **Reset during WAIT:** `rstn` low one cycle, then a late `mem_rsp_valid` arrives → response ignored, no `ifu_update`; a fresh LOOKUP of `pc` issues a new request.
